// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register for instruction/PC with valid/ready handshake,
// a one-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_skid_reg #(
    parameter int unsigned         INSTR_W   = 32,
    parameter int unsigned         PC_W      = 32,
    parameter logic [PC_W-1:0]     RESET_PC  = PC_W'(32'h0000_3000),
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(32'h0000_0000),
    parameter int unsigned         CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_W-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [PC_W-1:0]     out_pc,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   main_instr_d;
    logic [PC_W-1:0]      main_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic                 accept_c;
    logic                 take_c;

    assign accept_c = in_valid & in_ready;
    assign take_c   = out_valid & out_ready;

    // Next state and entry contents; out_instr/out_pc are the main entry itself.
    always_comb begin
        state_d      = state_q;
        main_instr_d = out_instr;
        main_pc_d    = out_pc;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (accept_c && take_c) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (accept_c) begin
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                    state_d      = TWO;
                end else if (take_c) begin
                    state_d      = EMPTY;
                end
            end
            TWO: begin
                if (take_c) begin
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d = EMPTY;
        end

        // Empty stage never exposes stale payload.
        if (state_d == EMPTY) begin
            main_instr_d = NOP_INSTR;
            main_pc_d    = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            occupancy    <= 2'd0;
            out_instr    <= NOP_INSTR;
            out_pc       <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= RESET_PC;
            stall_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            out_valid    <= (state_d != EMPTY);
            in_ready     <= (state_d != TWO);
            occupancy    <= state_d;
            out_instr    <= main_instr_d;
            out_pc       <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            // Saturating count of back-pressured cycles; flush does not touch it.
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed steps then random traffic, checked each
// cycle against a queue-based model of the two-entry stage.
module tb_pipe_skid_reg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int unsigned CNT_MAX = 15;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [1:0]         occupancy;
    logic [CNT_W-1:0]   stall_cnt;

    pipe_skid_reg #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_stall;
    int          total;
    int          bad;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        e_instr = (mq.size() > 0) ? mq[0].instr : NOP;
        e_pc    = (mq.size() > 0) ? mq[0].pc    : RST_PC;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("out_instr", out_instr, e_instr);
        chk("out_pc",    out_pc,    e_pc);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic cycle();
        bit   acc;
        bit   tk;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        tk  = (mq.size() > 0) && out_ready;
        if (!reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if ((mq.size() > 0) && !out_ready && (m_stall < CNT_MAX)) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (tk) void'(mq.pop_front());
                if (acc) begin
                    e.instr = in_instr;
                    e.pc    = in_pc;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic drive(input bit rst_n, input bit fl, input bit v,
                         input logic [31:0] pc, input bit ordy);
        reset     = rst_n;
        flush     = fl;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = $urandom;
        out_ready = ordy;
        cycle();
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; m_stall = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;

        // Reset held two cycles with input offered.
        drive(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1);
        chk("rst_pc", out_pc, RST_PC);

        // Streaming at full rate.
        drive(1'b1, 1'b0, 1'b1, 32'h3000, 1'b1);
        chk("stream0_pc", out_pc, 32'h3000);
        drive(1'b1, 1'b0, 1'b1, 32'h3004, 1'b1);
        chk("stream1_pc", out_pc, 32'h3004);
        drive(1'b1, 1'b0, 1'b1, 32'h3008, 1'b1);
        chk("stream2_pc", out_pc, 32'h3008);
        chk("stream_occ", 32'(occupancy), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Back-pressure fills the skid entry.
        drive(1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h3004, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h3008, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h3008, 1'b0);
        chk("bp_occ",   32'(occupancy), 32'd2);
        chk("bp_pc",    out_pc, 32'h3000);
        chk("bp_stall", 32'(stall_cnt), 32'd3);
        drive(1'b1, 1'b0, 1'b1, 32'h3008, 1'b1);
        chk("drain0_pc", out_pc, 32'h3004);
        drive(1'b1, 1'b0, 1'b1, 32'h3008, 1'b1);
        chk("drain1_pc", out_pc, 32'h3008);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Flush while full, with simultaneous accept and take.
        drive(1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h3004, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h300C, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_pc",  out_pc, RST_PC);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Stall counter saturation.
        drive(1'b1, 1'b0, 1'b1, 32'h3010, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sat_stall", 32'(stall_cnt), 32'd15);

        // Reset beats flush while full; first input after reset appears next cycle.
        drive(1'b1, 1'b0, 1'b1, 32'h3014, 1'b0);
        chk("full_before_rst", 32'(occupancy), 32'd2);
        drive(1'b0, 1'b1, 1'b1, 32'h3018, 1'b0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h301C, 1'b1);
        chk("post_rst_pc", out_pc, 32'h301C);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom,
                  ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID register: a pipeline-stage register carrying instruction and PC, with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating stall counter.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...).
- Lets upstream keep full throughput while downstream back-pressure is seen one cycle late through a registered ready.

Parameters:
INSTR_W, 32, instruction payload width
PC_W, 32, PC payload width
RESET_PC, 32'h0000_3000, out_pc value whenever out_valid=0
NOP_INSTR, 32'h0000_0000, out_instr value whenever out_valid=0
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream has data
in_ready  out  1  stage can accept; registered (function of state only)
in_instr  in  INSTR_W  upstream instruction
in_pc  in  PC_W  upstream PC
out_valid  out  1  main entry holds data
out_ready  in  1  downstream accepts
out_instr  out  INSTR_W  main entry instruction
out_pc  out  PC_W  main entry PC
occupancy  out  2  entries held: 0, 1 or 2
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry (drives out_*) and skid entry. FIFO order; skid is always younger than main.
- Handshakes: accept = in_valid & in_ready; take = out_valid & out_ready.
- States EMPTY (occ 0), ONE (occ 1), TWO (occ 2). in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY: accept -> main <= in, ONE. Latency 1 cycle from input to output.
- ONE:
  - accept & take -> main <= in, stay ONE (full throughput).
  - accept & !take -> skid <= in, TWO.
  - !accept & take -> EMPTY.
  - else hold.
- TWO: no accept possible.
  - take -> main <= skid, ONE.
  - else hold.
- out_valid=0: out_instr = NOP_INSTR, out_pc = RESET_PC. The last payload is never exposed after drain.
- Holding: entries never change while not taken; payload is stable under back-pressure.
- Flush (flush=1 at edge):
  - state -> EMPTY, both entries invalid.
  - Any accept or take in that cycle is discarded. The upstream handshake still completes but its data is dropped.
  - stall_cnt unaffected.
- Reset (reset=0 at edge):
  - state EMPTY, out_valid 0, in_ready 1, occupancy 0, out_instr NOP_INSTR, out_pc RESET_PC, stall_cnt 0.
  - Reset has priority over flush; mid-operation reset discards all entries.
- stall_cnt: increments by 1 each edge with out_valid & !out_ready. Saturates at all-ones with no wrap. Cleared only by reset.
- Widths: occupancy is 2-bit; the value 3 never occurs.

Test Plan:
- Reset held low 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_pc=32'h3000, out_instr=0, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, in_valid=1, PCs 0x3000,0x3004,0x3008 on consecutive cycles -> same PCs appear one cycle later each cycle; occupancy stays 1; in_ready stays 1.
- Back-pressure: send 0x3000, 0x3004, then drop out_ready for 3 cycles with in_valid=1 (PC 0x3008 offered) -> occupancy 2, in_ready=0, 0x3008 not taken, out_pc stays 0x3000, stall_cnt=3; raise out_ready -> outputs in order 0x3000, 0x3004, 0x3008, none lost or duplicated.
- Flush in state TWO with simultaneous in_valid (PC 0x300C) and out_ready=1 -> next cycle occupancy 0, out_valid=0, out_pc=RESET_PC; 0x300C never appears at the output.
- Saturation with CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds at 15.
- Reset asserted while occupancy=2 and flush=1 -> next cycle full reset values; first post-reset input appears after 1 cycle.
